kernel_gemm_param: RTL
======================

KERNEL_GEMM_PARAM -- requirements
Module: kernel_gemm_param

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NI, 8, rows of A and D.
- NJ, 8, columns of B and D.
- NK, 8, shared dimension; legal range 1..256.
- DATA_W, 32, element width, two's complement.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk in 1 — clock.
- rst in 1 — reset, asynchronous, active-low.
- ap_start in 1 — start request.
- ap_done out 1 — run complete.
- ap_idle out 1 — block idle.
- ap_ready out 1 — inputs consumed.
- mode in 1 — 0: D=alpha*A*B; 1: D=alpha*A*B+beta*C.
- alpha in DATA_W — scale for A*B.
- beta in DATA_W — scale for C.
- A_address0 out clog2(NI*NK), A_ce0 out 1, A_q0 in DATA_W — A read port, row-major.
- B_address0 out clog2(NK*NJ), B_ce0 out 1, B_q0 in DATA_W — B read port, row-major.
- C_address0 out clog2(NI*NJ), C_ce0 out 1, C_q0 in DATA_W — C read port.
- D_address1 out clog2(NI*NJ), D_ce1 out 1, D_we1 out 1, D_d1 out DATA_W — D write port.
REQ-003 Every read port SHALL assume 1-cycle latency: q is valid in the cycle after ce=1.

Function
REQ-004 FSM states SHALL be IDLE, INIT, MAC, DRAIN, WRITE, DONE.
REQ-005 IDLE: ap_idle=1; ap_start=1 SHALL latch mode, alpha and beta, set i=j=0, go to INIT next cycle.
REQ-006 Output elements SHALL be processed row-major (i outer, j inner); each element takes exactly NK+3 cycles.
REQ-007 INIT (1 cycle): clear acc; if mode=1, assert C_ce0 with C_address0=i*NJ+j, else keep C_ce0=0.
REQ-008 MAC (NK cycles, k=0..NK-1):
- assert A_ce0/B_ce0 with addresses i*NK+k and k*NJ+j;
- each cycle, add the product returned for the previous k into acc;
- in the first MAC cycle, latch C_q0 into c_reg when mode=1.
REQ-009 DRAIN (1 cycle): accumulate the final product; no memory strobes.
REQ-010 WRITE (1 cycle):
- D_ce1=D_we1=1, D_address1=i*NJ+j;
- D_d1 = alpha*acc + (mode ? beta*c_reg : 0);
- then advance j, wrapping to 0 with i+1; after element (NI-1,NJ-1) go to DONE, else INIT.
REQ-011 Arithmetic: all products and sums SHALL be taken modulo 2^DATA_W; acc is DATA_W bits and wraps silently.
REQ-012 DONE (1 cycle): ap_done=1 and ap_ready=1 for exactly this cycle, then IDLE.
REQ-013 Latency: with ap_start accepted in cycle 0, ap_done SHALL assert in cycle 1+NI*NJ*(NK+3).
REQ-014 ap_start outside IDLE SHALL be ignored; changes to alpha, beta or mode after acceptance SHALL have no effect on the run.
REQ-015 ap_start held high SHALL start the next run in the IDLE cycle following DONE.
REQ-016 All ce/we strobes SHALL be 0 in every state and cycle not listed above.

Reset
REQ-017 rst=0 SHALL immediately force: state IDLE, ap_idle=1, ap_done=ap_ready=0, all ce/we=0, all addresses, D_d1, acc, c_reg, i, j and k = 0.
REQ-018 A reset asserted mid-run SHALL abort the run; no D write occurs until a new ap_start is accepted after rst returns to 1.

Structure
REQ-019 Package kernel_gemm_pkg SHALL hold the FSM state enum and the address-width helper functions.
REQ-020 The multiply-accumulate datapath SHALL be one sub-module, kernel_gemm_mac (clear, enable, operands, acc out).

Verification
REQ-021 NI=NJ=NK=2, mode=0, alpha=1, A=identity, B=[[1,2],[3,4]], start in cycle 0 -> D=[[1,2],[3,4]]; ap_done only in cycle 21; C_ce0 never 1.
REQ-022 NI=NJ=NK=2, mode=1, alpha=3, beta=2, A=B=all 1, C=all 10 -> every D element = 26; exactly 4 D_we1 pulses.
REQ-023 DATA_W=8, NI=NJ=NK=1, mode=0, alpha=1, A=B=16 -> D_d1=0 (wrap); ap_done in cycle 5.
REQ-024 Config of REQ-021 with rst=0 in cycle 7 -> all outputs at reset values in the same cycle; no D_we1 afterwards; ap_idle=1.
REQ-025 Config of REQ-021 with ap_start held high -> ap_done in cycles 21 and 43; ap_start pulses in cycles 3–10 are ignored.

Source files
------------

// File: rtl/kernel_gemm_pkg.sv
// kernel_gemm_pkg -- shared definitions for the GEMM kernel.
//   state_t : controller state encoding (also exported on the debug port)
//   addr_w  : width of an address bus for a memory of 'depth' words
//   cnt_w   : width of a loop counter that must hold 0..n-1
// Both helpers return at least 1 so degenerate sizes (e.g. 1x1) still
// produce legal one-bit buses.
package kernel_gemm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic int addr_w(input int depth);
    if (depth <= 1) return 1;
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int n);
    return addr_w(n);
  endfunction

endpackage

// File: rtl/kernel_gemm_mac.sv
// kernel_gemm_mac -- multiply-accumulate datapath.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears the accumulator
//   clear_i : synchronous clear (takes priority over en_i)
//   en_i    : add a_i*b_i into the accumulator this cycle
//   a_i/b_i : operands, two's complement
//   acc_o   : accumulator, DATA_W bits, wraps modulo 2^DATA_W
module kernel_gemm_mac
  import kernel_gemm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] prod;

  // Low DATA_W bits of the product are identical for signed and unsigned
  // operands, so no sign handling is needed under modular arithmetic.
  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clear_i)   acc_d = '0;
    else if (en_i) acc_d = acc_q + prod;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/kernel_gemm_param.sv
// kernel_gemm_param -- D = alpha*A*B (+ beta*C), one output element at a time.
// Ports:
//   clk, rst (async active-low)      : clock / reset
//   ap_start, ap_done, ap_idle,
//   ap_ready                         : block-level control
//   mode, alpha, beta                : run configuration, latched at start
//   A_*, B_*, C_*                    : read ports, data valid one cycle after ce
//   D_*                              : write port
//   dbg_state_o                      : current controller state
// Handshake: ap_start is sampled only while idle; acceptance latches
// mode/alpha/beta. ap_done and ap_ready pulse together for the single DONE
// cycle. ap_start held high restarts in the IDLE cycle after DONE.
// Per element: INIT (C read), NK x MAC (A/B reads, product of k-1 added),
// DRAIN (last product added), WRITE (D store) = NK+3 cycles.
module kernel_gemm_param
  import kernel_gemm_pkg::*;
#(
  parameter  int NI     = 8,
  parameter  int NJ     = 8,
  parameter  int NK     = 8,
  parameter  int DATA_W = 32,
  localparam int A_AW   = addr_w(NI * NK),
  localparam int B_AW   = addr_w(NK * NJ),
  localparam int C_AW   = addr_w(NI * NJ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic              mode,
  input  logic [DATA_W-1:0] alpha,
  input  logic [DATA_W-1:0] beta,
  output logic [A_AW-1:0]   A_address0,
  output logic              A_ce0,
  input  logic [DATA_W-1:0] A_q0,
  output logic [B_AW-1:0]   B_address0,
  output logic              B_ce0,
  input  logic [DATA_W-1:0] B_q0,
  output logic [C_AW-1:0]   C_address0,
  output logic              C_ce0,
  input  logic [DATA_W-1:0] C_q0,
  output logic [C_AW-1:0]   D_address1,
  output logic              D_ce1,
  output logic              D_we1,
  output logic [DATA_W-1:0] D_d1,
  output logic [2:0]        dbg_state_o
);

  localparam int I_W = cnt_w(NI);
  localparam int J_W = cnt_w(NJ);
  localparam int K_W = cnt_w(NK);
  localparam logic [I_W-1:0] I_LAST = I_W'(NI - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(NJ - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(NK - 1);

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] alpha_q, alpha_d;
  logic [DATA_W-1:0] beta_q, beta_d;
  logic [DATA_W-1:0] c_reg_q, c_reg_d;
  logic [I_W-1:0]    i_q, i_d;
  logic [J_W-1:0]    j_q, j_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [DATA_W-1:0] acc;
  logic              mac_clr, mac_en;
  logic [DATA_W-1:0] wr_val;
  logic [A_AW-1:0]   a_addr;
  logic [B_AW-1:0]   b_addr;
  logic [C_AW-1:0]   cd_addr;

  // Index products stay below the memory depth, so computing them at the
  // bus width loses nothing.
  assign a_addr  = A_AW'(i_q) * A_AW'(NK) + A_AW'(k_q);
  assign b_addr  = B_AW'(k_q) * B_AW'(NJ) + B_AW'(j_q);
  assign cd_addr = C_AW'(i_q) * C_AW'(NJ) + C_AW'(j_q);

  // Clear at INIT; the first MAC cycle has no returned product yet.
  assign mac_clr = (state_q == ST_INIT);
  assign mac_en  = ((state_q == ST_MAC) && (k_q != '0)) || (state_q == ST_DRAIN);

  kernel_gemm_mac #(.DATA_W(DATA_W)) u_mac (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clear_i (mac_clr),
    .en_i    (mac_en),
    .a_i     (A_q0),
    .b_i     (B_q0),
    .acc_o   (acc)
  );

  assign wr_val = alpha_q * acc + (mode_q ? beta_q * c_reg_q : '0);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    c_reg_d = c_reg_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          mode_d  = mode;
          alpha_d = alpha;
          beta_d  = beta;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        k_d     = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        // C data requested in INIT is valid now.
        if ((k_q == '0) && mode_q) c_reg_d = C_q0;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_WRITE;
      ST_WRITE: begin
        if (j_q == J_LAST) begin
          j_d = '0;
          if (i_q == I_LAST) begin
            i_d     = '0;
            state_d = ST_DONE;
          end else begin
            i_d     = i_q + I_W'(1);
            state_d = ST_INIT;
          end
        end else begin
          j_d     = j_q + J_W'(1);
          state_d = ST_INIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      alpha_q <= '0;
      beta_q  <= '0;
      c_reg_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      c_reg_q <= c_reg_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Outputs decode registered state only, so reset clears them at once.
  always_comb begin
    A_ce0      = 1'b0;
    B_ce0      = 1'b0;
    C_ce0      = 1'b0;
    D_ce1      = 1'b0;
    D_we1      = 1'b0;
    A_address0 = '0;
    B_address0 = '0;
    C_address0 = '0;
    D_address1 = '0;
    D_d1       = '0;
    case (state_q)
      ST_INIT: begin
        if (mode_q) begin
          C_ce0      = 1'b1;
          C_address0 = cd_addr;
        end
      end
      ST_MAC: begin
        A_ce0      = 1'b1;
        B_ce0      = 1'b1;
        A_address0 = a_addr;
        B_address0 = b_addr;
      end
      ST_WRITE: begin
        D_ce1      = 1'b1;
        D_we1      = 1'b1;
        D_address1 = cd_addr;
        D_d1       = wr_val;
      end
      default: ;
    endcase
  end

  assign ap_idle     = (state_q == ST_IDLE);
  assign ap_done     = (state_q == ST_DONE);
  assign ap_ready    = (state_q == ST_DONE);
  assign dbg_state_o = state_q;

endmodule
